// File: rtl/mult_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default sizes,
// the response tag carried alongside each multiply, and a small helper.
package mult_share_arb_pkg;

   localparam int N_DEF    = 4;   // operand width
   localparam int NREQ_DEF = 4;   // number of requesters
   localparam int LAT_DEF  = 4;   // multiplier latency in clk edges

   // Requester index width; the tag struct and priority pointer use it,
   // so a wider requester count needs this default raised as well.
   localparam int IDX_W = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

   // One tag stage: does this slot carry a live operation, and for whom.
   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;

   // Advance a requester index by one, wrapping at nreq.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i,
                                                 input int nreq);
      int n;
      n = int'(i) + 1;
      if (n >= nreq) n = 0;
      return IDX_W'(n);
   endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Bundle of the request, multiplier and response signals of the arbiter.
// slave = the arbiter side, master = requesters plus the external multiplier.
interface mult_share_arb_if
   import mult_share_arb_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int LAT  = LAT_DEF
);

   logic [NREQ-1:0]          req_valid;
   logic [NREQ*N-1:0]        req_a;
   logic [NREQ*N-1:0]        req_b;
   logic [NREQ-1:0]          req_ready;
   logic [N-1:0]             mul_a;
   logic [N-1:0]             mul_b;
   logic [2*N-1:0]           mul_p;
   logic [NREQ-1:0]          rsp_valid;
   logic [2*N-1:0]           rsp_data;
   logic [$clog2(LAT+1)-1:0] inflight;

   modport slave (
      input  req_valid, req_a, req_b, mul_p,
      output req_ready, mul_a, mul_b, rsp_valid, rsp_data, inflight
   );

   modport master (
      output req_valid, req_a, req_b, mul_p,
      input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, inflight
   );

endinterface

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational round-robin picker: starting at ptr and wrapping, returns
// the first set bit of valid as a one-hot grant plus its index.
module rr_pick
   import mult_share_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = IDX_W
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   index,
   output logic            found
);

   // Walk the requesters in priority order ptr, ptr+1, ... and stop at the first hit.
   always_comb begin
      int            c;
      logic [IW-1:0] ci;
      grant = '0;
      index = '0;
      found = 1'b0;
      c     = 0;
      ci    = '0;
      for (int k = 0; k < NREQ; k++) begin
         c = int'(ptr) + k;
         if (c >= NREQ) c = c - NREQ;
         ci = IW'(c);
         if (!found && valid[ci]) begin
            found     = 1'b1;
            grant[ci] = 1'b1;
            index     = ci;
         end
      end
   end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one external pipelined multiplier among NREQ requesters.
// A round-robin grant issues at most one operation per cycle; a tag pipeline
// of LAT stages, matching the multiplier latency, routes each product back
// to the requester that issued it.
module mult_share_arb
   import mult_share_arb_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int LAT  = LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   mult_share_arb_if.slave  bus
);

   localparam int IW = IDX_W;
   localparam int CW = $clog2(LAT + 1);

   logic [N-1:0]    a_arr [NREQ];
   logic [N-1:0]    b_arr [NREQ];

   logic [IW-1:0]   ptr_q, ptr_d;
   tag_t            tag_q [LAT];
   tag_t            tag_d [LAT];
   logic [CW-1:0]   inflight_q, inflight_d;

   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_found;
   logic            issue;
   tag_t            tag_last;

   // Unpack the per-requester operand slices.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a[gi*N +: N];
         assign b_arr[gi] = bus.req_b[gi*N +: N];
      end
   endgenerate

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .valid (bus.req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .index (pick_idx),
      .found (pick_found)
   );

   // Issue qualification, grant and operand steering; held quiet during reset.
   always_comb begin
      issue         = rst_n & en & pick_found;
      bus.req_ready = '0;
      bus.mul_a     = '0;
      bus.mul_b     = '0;
      if (issue) begin
         bus.req_ready = pick_grant;
         bus.mul_a     = a_arr[pick_idx];
         bus.mul_b     = b_arr[pick_idx];
      end
   end

   // Next pointer: one past the winner on issue, otherwise unchanged.
   always_comb begin
      ptr_d = ptr_q;
      if (issue) ptr_d = wrap_inc(pick_idx, NREQ);
   end

   // Tag pipeline shifts every cycle and loads the current issue at stage 0.
   always_comb begin
      tag_d[0].vld = issue;
      tag_d[0].idx = pick_idx;
   end

   generate
      for (genvar gi = 1; gi < LAT; gi++) begin : g_tag_shift
         assign tag_d[gi] = tag_q[gi-1];
      end
   endgenerate

   assign tag_last = tag_q[LAT-1];

   // Response decode: the last tag stage lines up with the multiplier output.
   always_comb begin
      bus.rsp_valid = '0;
      if (tag_last.vld) bus.rsp_valid[tag_last.idx] = 1'b1;
   end

   assign bus.rsp_data = bus.mul_p;
   assign bus.inflight = inflight_q;

   // Outstanding count: +1 on issue, -1 on response, hold when both or neither.
   always_comb begin
      inflight_d = inflight_q;
      unique case ({issue, tag_last.vld})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // State registers; reset discards every in-flight tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         inflight_q <= '0;
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
      end
   end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios plus a random run, checked
// against a queue-based model of issued operations and their due cycles.
module tb_mult_share_arb;

   localparam int N    = 4;
   localparam int NREQ = 4;
   localparam int LAT  = 4;

   logic clk;
   logic rst_n;
   logic en;

   mult_share_arb_if #(.N(N), .NREQ(NREQ), .LAT(LAT)) bus ();

   mult_share_arb #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .bus   (bus)
   );

   // External multiplier model: LAT register stages, unsigned product.
   logic [2*N-1:0] p_pipe [LAT];
   always_ff @(posedge clk) begin
      p_pipe[0] <= {{N{1'b0}}, bus.mul_a} * {{N{1'b0}}, bus.mul_b};
      for (int i = 1; i < LAT; i++) p_pipe[i] <= p_pipe[i-1];
   end
   assign bus.mul_p = p_pipe[LAT-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int prod;
      int due;
   } exp_t;

   exp_t q[$];
   int   m_ptr;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   peak;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Drive one cycle of inputs after the edge, then check at the falling edge.
   task automatic run_cycle(input logic rst_v, input logic en_v, input logic [NREQ-1:0] vld,
                            input logic [NREQ*N-1:0] a, input logic [NREQ*N-1:0] b);
      int w;
      int ai, bi, ri;
      logic [NREQ*N-1:0] av, bv;
      @(posedge clk);
      #1;
      rst_n         = rst_v;
      en            = en_v;
      bus.req_valid = vld;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge clk);
      cyc++;
      av = a;
      bv = b;
      if (32'(bus.inflight) > peak) peak = 32'(bus.inflight);
      if (!rst_v) begin
         q.delete();
         m_ptr = 0;
         check_eq("rst_ready",    32'(bus.req_ready), 32'd0);
         check_eq("rst_rsp",      32'(bus.rsp_valid), 32'd0);
         check_eq("rst_inflight", 32'(bus.inflight),  32'd0);
         check_eq("rst_mul_a",    32'(bus.mul_a),     32'd0);
         return;
      end
      // Expected winner: first valid requester at or after the pointer.
      w = -1;
      if (en_v) begin
         for (int k = 0; k < NREQ; k++) begin
            ri = (m_ptr + k) % NREQ;
            if (vld[ri]) begin
               w = ri;
               break;
            end
         end
      end
      check_eq("inflight", 32'(bus.inflight), 32'(q.size()));
      if (w >= 0) begin
         ai = int'(av[w*N +: N]);
         bi = int'(bv[w*N +: N]);
         check_eq("ready", 32'(bus.req_ready), 32'(1) << w);
         check_eq("mul_a", 32'(bus.mul_a), 32'(ai));
         check_eq("mul_b", 32'(bus.mul_b), 32'(bi));
      end else begin
         check_eq("ready_idle", 32'(bus.req_ready), 32'd0);
         check_eq("mul_idle",   32'({bus.mul_a, bus.mul_b}), 32'd0);
      end
      // Expected response: the oldest operation whose latency has elapsed.
      if (q.size() > 0 && q[0].due == cyc) begin
         check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(1) << q[0].idx);
         check_eq("rsp_data",  32'(bus.rsp_data),  32'(q[0].prod));
         $display("cycle %0d rsp  req=%0d data=%0d", cyc, q[0].idx, bus.rsp_data);
         void'(q.pop_front());
      end else begin
         check_eq("rsp_none", 32'(bus.rsp_valid), 32'd0);
      end
      if (w >= 0) begin
         q.push_back('{idx: w, prod: ai * bi, due: cyc + LAT});
         m_ptr = (w + 1) % NREQ;
         $display("cycle %0d issue req=%0d a=%0d b=%0d", cyc, w, ai, bi);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle(1'b1, 1'b1, '0, '0, '0);
   endtask

   task automatic do_reset();
      run_cycle(1'b0, 1'b1, '1, '1, '1);
      run_cycle(1'b0, 1'b1, '1, '1, '1);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      cyc           = 0;
      m_ptr         = 0;
      peak          = 0;
      rst_n         = 1'b0;
      en            = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // Reset with all requests asserted: nothing may be granted.
      do_reset();

      // Single op 2*15 from requester 0, issued right after release.
      run_cycle(1'b1, 1'b1, 4'b0001, 16'h000_2, 16'h000_F);
      idle(6);

      // All four valid from ptr=0: grants 0,1,2,3,0,... back to back.
      do_reset();
      for (int i = 0; i < 8; i++)
         run_cycle(1'b1, 1'b1, 4'b1111, 16'h4321, 16'h8765);
      idle(6);

      // Move ptr to 2, then 1010: grants 3,1,3.
      do_reset();
      run_cycle(1'b1, 1'b1, 4'b0010, 16'h0030, 16'h0050);
      for (int i = 0; i < 3; i++)
         run_cycle(1'b1, 1'b1, 4'b1010, 16'hB0C0, 16'h9070);
      idle(6);

      // Consecutive (10,7), (7,7), (10,12) -> 70, 49, 120; inflight peaks at 3.
      do_reset();
      peak = 0;
      run_cycle(1'b1, 1'b1, 4'b0001, 16'h000A, 16'h0007);
      run_cycle(1'b1, 1'b1, 4'b0001, 16'h0007, 16'h0007);
      run_cycle(1'b1, 1'b1, 4'b0001, 16'h000A, 16'h000C);
      idle(6);
      check_eq("peak_inflight", 32'(peak), 32'd3);

      // Reset with three in flight: nothing returns after release.
      run_cycle(1'b1, 1'b1, 4'b0100, 16'h0300, 16'h0500);
      run_cycle(1'b1, 1'b1, 4'b0100, 16'h0600, 16'h0700);
      run_cycle(1'b1, 1'b1, 4'b0100, 16'h0900, 16'h0200);
      idle(1);
      check_eq("pre_rst_inflight", 32'(bus.inflight), 32'd3);
      run_cycle(1'b0, 1'b1, '0, '0, '0);
      idle(8);
      check_eq("post_rst_inflight", 32'(bus.inflight), 32'd0);
      // ptr back at 0: all valid must grant requester 0.
      run_cycle(1'b1, 1'b1, 4'b1111, 16'h1111, 16'h2222);
      check_eq("post_rst_ptr", 32'(bus.req_ready), 32'd1);
      idle(6);

      // en low with all valid: no grants, issued work still drains.
      run_cycle(1'b1, 1'b1, 4'b1111, 16'hFEDC, 16'hBA98);
      run_cycle(1'b1, 1'b1, 4'b1111, 16'hFEDC, 16'hBA98);
      for (int i = 0; i < 6; i++)
         run_cycle(1'b1, 1'b0, 4'b1111, 16'hFEDC, 16'hBA98);
      idle(2);

      // Random traffic with occasional enable drops and resets.
      for (int i = 0; i < 500; i++) begin
         run_cycle(($urandom % 97) != 0, ($urandom % 8) != 0,
                   NREQ'($urandom), (NREQ*N)'($urandom), (NREQ*N)'($urandom));
      end
      idle(LAT + 2);
      check_eq("final_queue", 32'(bus.inflight), 32'(q.size()));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_share_arb.md
MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
- REQ-001 Parameter: N, default 4, operand width in bits.
- REQ-002 Parameter: NREQ, default 4, number of requesters.
- REQ-003 Parameter: LAT, default 4, multiplier latency in clk edges from operand presentation to product.
- REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
- REQ-006 Port: en  input  1  issue enable; low blocks new grants.
- REQ-007 Port: req_valid  input  NREQ  per-requester operation request.
- REQ-008 Port: req_a  input  NREQ*N  packed operand A; requester i uses bits [i*N +: N].
- REQ-009 Port: req_b  input  NREQ*N  packed operand B, same packing as req_a.
- REQ-010 Port: req_ready  output  NREQ  one-hot grant; an operation issues when req_valid[i] and req_ready[i] are both high.
- REQ-011 Port: mul_a  output  N  operand A to the shared pipelined multiplier.
- REQ-012 Port: mul_b  output  N  operand B to the shared pipelined multiplier.
- REQ-013 Port: mul_p  input  2N  product from the multiplier.
- REQ-014 Port: rsp_valid  output  NREQ  one-hot; marks a result for requester i.
- REQ-015 Port: rsp_data  output  2N  result, equal to mul_p.
- REQ-016 Port: inflight  output  clog2(LAT+1)  number of issued operations not yet returned.

Function
- REQ-017 Grant SHALL be round-robin and combinational from req_valid, en and the priority pointer ptr.
- REQ-018 The winner SHALL be the first i with req_valid[i] set, searching ptr, ptr+1, ..., wrapping modulo NREQ.
- REQ-019 At most one req_ready bit SHALL be high per cycle; all bits SHALL be low when en=0 or no request is valid.
- REQ-020 On issue by requester w, ptr SHALL become (w+1) mod NREQ at the next edge; otherwise ptr SHALL hold.
- REQ-021 mul_a and mul_b SHALL carry the winner's operands during the issue cycle and SHALL be 0 when no operation issues.
- REQ-022 A tag pipeline of LAT stages, each holding {valid, index}, SHALL shift every cycle and load {issue, w} at stage 0.
- REQ-023 rsp_valid SHALL be the one-hot decode of the last tag stage's index, qualified by its valid bit.
- REQ-024 Timing: an operation issued at edge t SHALL produce rsp_valid exactly LAT edges later, for exactly 1 cycle.
- REQ-025 Back-to-back issues SHALL be supported: one issue per cycle with no bubbles, full pipeline throughput.
- REQ-026 Responses SHALL NOT be backpressured, and they SHALL return in issue order.
- REQ-027 inflight SHALL increment on issue only, decrement on response only, and hold when both or neither occur; its range is 0..LAT.
- REQ-028 en falling SHALL block new grants only; in-flight operations SHALL still return.
- REQ-029 A requester dropping req_valid without issuing SHALL lose nothing and SHALL not move ptr.
- REQ-030 Arithmetic: mul_p is the unsigned N x N product; this block SHALL not modify it.

Reset
- REQ-031 While rst_n=0, ptr SHALL be 0, all tag stages invalid, inflight 0, rsp_valid 0 and req_ready 0.
- REQ-032 A reset asserted mid-operation SHALL discard in-flight tags, and no rsp_valid SHALL follow from them after release.
- REQ-033 Issue SHALL be possible on the first rising edge after rst_n rises.

Structure
- REQ-034 A shared package SHALL hold the defaults for N, NREQ and LAT and a tag struct {logic vld; logic [clog2(NREQ)-1:0] idx}.
- REQ-035 One sub-module SHALL exist: rr_pick, a combinational round-robin one-hot picker taking (valid, ptr) and returning (grant, index).
- REQ-036 The multiplier SHALL be external; the bench SHALL instantiate a LAT=4 pipelined multiplier model.

Verification
- REQ-037 After reset, req_valid=4'b0001, a0=2, b0=15 issued at edge t -> rsp_valid=4'b0001 and rsp_data=30 at edge t+4; inflight goes 1 then back to 0.
- REQ-038 All four requesters valid continuously from ptr=0 -> grants in order 0,1,2,3,0; rsp_valid follows the same order 4 cycles later with no gaps.
- REQ-039 req_valid=4'b1010 with ptr=2 -> grant to requester 3, then to requester 1, then to requester 3.
- REQ-040 Issues (10,7), (7,7) and (10,12) on consecutive cycles -> results 70, 49 and 120 on consecutive cycles; inflight peaks at 3.
- REQ-041 Reset asserted with inflight=3 -> no rsp_valid pulse after release; inflight=0 and ptr=0.
- REQ-042 en=0 with all requests valid -> req_ready=0 and mul_a=mul_b=0, while already-issued results still return.
